// File: rtl/eth_stats_pkg.sv
// Shared definitions for the Ethernet statistics monitor: MAC status event
// indices and the {channel, index} read-address packing.
package eth_stats_pkg;

    localparam int TX_FIFO_OVERFLOW = 0;
    localparam int TX_FIFO_BAD      = 1;
    localparam int TX_FIFO_GOOD     = 2;
    localparam int TX_UNDERFLOW     = 3;
    localparam int RX_BAD_FRAME     = 4;
    localparam int RX_BAD_FCS       = 5;
    localparam int RX_FIFO_OVERFLOW = 6;
    localparam int RX_FIFO_BAD      = 7;
    localparam int RX_FIFO_GOOD     = 8;

    localparam int MAC_EVENTS    = 9;
    // The link-down counter sits just past the last event counter.
    localparam int LINK_DOWN_IDX = MAC_EVENTS;

    function automatic int unsigned idx_width(input int unsigned events);
        return $clog2(events + 1);
    endfunction

    function automatic logic [31:0] pack_addr(input int unsigned channel,
                                              input int unsigned index,
                                              input int unsigned idx_w);
        return (32'(channel) << idx_w) | 32'(index);
    endfunction

endpackage

// File: rtl/eth_link_debounce.sv
// One port's block-lock debounce: link_up after LOCK_CYCLES consecutive
// high samples, plus a one-cycle link_drop strobe when an up link is lost.
module eth_link_debounce
    import eth_stats_pkg::*;
#(
    parameter int LOCK_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic block_lock,
    output logic link_up,
    output logic link_drop
);

    localparam int TW = $clog2(LOCK_CYCLES + 1);
    localparam logic [TW-1:0] LOCK_MAX = TW'(LOCK_CYCLES);

    logic [TW-1:0] lock_timer;
    logic [TW-1:0] timer_next;

    always_comb begin
        // NOTE: default first so every path assigns timer_next and no latch is inferred.
        timer_next = lock_timer;
        if (!block_lock) begin
            timer_next = '0;
        end else if (lock_timer != LOCK_MAX) begin
            timer_next = lock_timer + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            lock_timer <= '0;
            link_up    <= 1'b0;
        end else begin
            lock_timer <= timer_next;
            link_up    <= (timer_next == LOCK_MAX);
        end
    end

    // Counted on the same edge that clears link_up.
    assign link_drop = link_up & ~block_lock;

endmodule

// File: rtl/eth_stats_monitor.sv
// Per-port saturating event counters, link-down counters and debounced
// link state, exposed through a one-cycle registered read port.
module eth_stats_monitor
    import eth_stats_pkg::*;
#(
    parameter int CHANNELS      = 1,
    parameter int EVENTS        = 9,
    parameter int CNT_WIDTH     = 32,
    parameter int LOCK_CYCLES   = 1024,
    parameter int CLEAR_ON_READ = 1,
    localparam int IDX_W        = $clog2(EVENTS + 1),
    localparam int ADDR_WIDTH   = $clog2(CHANNELS) + IDX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*EVENTS-1:0]   stat_pulse,
    input  logic [CHANNELS-1:0]          block_lock,
    input  logic                         clear_all,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic                         rd_valid,
    output logic [CNT_WIDTH-1:0]         rd_data,
    output logic [CHANNELS-1:0]          link_up
);

    localparam int SLOTS = EVENTS + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0]      rd_idx;
    logic [ADDR_WIDTH-1:0] rd_ch;
    logic [CNT_WIDTH-1:0]  counts [CHANNELS][SLOTS];
    logic [CHANNELS-1:0]   link_drop;
    logic [CNT_WIDTH-1:0]  rd_value;

    assign rd_idx = rd_addr[IDX_W-1:0];
    assign rd_ch  = rd_addr >> IDX_W;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        eth_link_debounce #(
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_debounce (
            .clk        (clk),
            .rst        (rst),
            .block_lock (block_lock[c]),
            .link_up    (link_up[c]),
            .link_drop  (link_drop[c])
        );

        for (genvar i = 0; i < SLOTS; i++) begin : g_cnt
            logic                 fire;
            logic                 sel;
            logic                 clr;
            logic [CNT_WIDTH-1:0] count;

            if (i < EVENTS) begin : g_evt
                assign fire = stat_pulse[c*EVENTS + i];
            end else begin : g_lnk
                assign fire = link_drop[c];
            end

            assign sel = (int'(rd_ch) == c) && (int'(rd_idx) == i);
            assign clr = clear_all || ((CLEAR_ON_READ != 0) && rd_en && sel);

            // An event coinciding with a clear leaves 1 behind so it is never lost.
            always_ff @(posedge clk or posedge rst) begin
                // NOTE: counters are architectural state, so each one is reset, not just the read path.
                if (rst) begin
                    count <= '0;
                end else if (clr) begin
                    count <= fire ? CNT_WIDTH'(1) : '0;
                end else if (fire && (count != CNT_MAX)) begin
                    count <= count + CNT_WIDTH'(1);
                end
            end

            assign counts[c][i] = count;
        end
    end

    // Out-of-range addresses match no slot and read back as zero.
    always_comb begin
        rd_value = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < SLOTS; i++) begin
                if ((int'(rd_ch) == c) && (int'(rd_idx) == i)) begin
                    rd_value = counts[c][i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_value;
            end
        end
    end

endmodule
